// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I front-end types and constants
//
// Purpose: fetch FSM state encoding, architectural width and the NOP
// encoding used to initialise the decode-side instruction register.
// Ports: none (package).

package rv32i_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch sequencer memory, decode and redirect bundle
//
// Purpose: groups the instruction-memory request/grant/response channel,
// the decode valid/ready channel and the execute redirect channel.
// Modports:
//   master - the fetch sequencer (drives imem_req/imem_addr and if_*)
//   slave  - the environment (memory, decode and execute stages)
// Signals:
//   imem_req, imem_addr            request and word-aligned fetch address
//   imem_gnt                       request accepted this cycle
//   imem_rvalid, imem_rdata        response word
//   if_valid, if_instr, if_pc      held instruction for decode
//   if_ready                       decode accepts this cycle
//   redirect_valid, redirect_pc    taken branch / jump target from execute

interface fetch_sequencer_if;
  import rv32i_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - RV32I instruction-fetch sequencer
//
// Purpose: owns the program counter, issues one fetch at a time to
// instruction memory, holds the returned word for decode and applies
// execute-stage redirects, discarding any response made stale by one.
// Parameters:
//   RESET_PC   address of the first fetch after reset
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        fetch_sequencer_if.master (memory, decode, redirect)
// Every output comes straight from a flop; no input reaches an output
// combinationally.

module fetch_sequencer
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst_n,
  fetch_sequencer_if.master  bus
);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            drop, drop_n;
  logic [XLEN-1:0] instr_q, instr_n;
  logic [XLEN-1:0] ipc_q, ipc_n;
  logic            req_q, req_n;
  logic            valid_q, valid_n;
  logic [XLEN-1:0] target;

  // Redirect targets are forced to word alignment.
  assign target = {bus.redirect_pc[XLEN-1:2], 2'b00};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = REQ;
      REQ:  if (bus.imem_gnt) state_n = WAIT;
      WAIT: begin
        if (bus.imem_rvalid) begin
          // A stale or freshly redirected response goes back to fetch.
          state_n = (drop || bus.redirect_valid) ? REQ : HOLD;
        end
      end
      HOLD: if (bus.redirect_valid || bus.if_ready) state_n = REQ;
      default: state_n = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    pc_n    = pc;
    drop_n  = drop;
    instr_n = instr_q;
    ipc_n   = ipc_q;
    case (state)
      REQ: begin
        // The granted fetch is for the old pc; its response must die.
        if (bus.imem_gnt && bus.redirect_valid) drop_n = 1'b1;
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          drop_n = 1'b0;
          if (!drop && !bus.redirect_valid) begin
            instr_n = bus.imem_rdata;
            ipc_n   = pc;
          end
        end else if (bus.redirect_valid) begin
          drop_n = 1'b1;
        end
      end
      HOLD: begin
        if (bus.if_ready && !bus.redirect_valid) pc_n = pc + 32'd4;
      end
      default: ;
    endcase
    // A redirect wins over every other pc update, in every state.
    if (bus.redirect_valid) pc_n = target;
    req_n   = (state_n == REQ);
    valid_n = (state_n == HOLD);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      drop    <= 1'b0;
      instr_q <= NOP_INSTR;
      ipc_q   <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pc      <= pc_n;
      drop    <= drop_n;
      instr_q <= instr_n;
      ipc_q   <= ipc_n;
      req_q   <= req_n;
      valid_q <= valid_n;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc;
  assign bus.if_valid  = valid_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = ipc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed table and randomized model checks for fetch_sequencer

module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(32'h0000_0100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic g, logic rv, logic [31:0] rd, logic rdy,
                              logic rdr, logic [31:0] rp, logic er,
                              logic [31:0] ea, logic ev, logic [31:0] ep,
                              logic [31:0] ei);
    vec_t t;
    t.gnt = g; t.rvalid = rv; t.rdata = rd; t.ready = rdy; t.redir = rdr;
    t.rpc = rp; t.e_req = er; t.e_addr = ea; t.e_valid = ev; t.e_pc = ep;
    t.e_instr = ei;
    return t;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic rdr, input logic [31:0] rp);
    bus.imem_gnt       = g;
    bus.imem_rvalid    = rv;
    bus.imem_rdata     = rd;
    bus.if_ready       = rdy;
    bus.redirect_valid = rdr;
    bus.redirect_pc    = rp;
  endtask

  // Drive at negedge, let one rising edge pass, compare at the next negedge.
  task automatic apply(input vec_t t, input string tag);
    drive(t.gnt, t.rvalid, t.rdata, t.ready, t.redir, t.rpc);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".req"}, 32'(bus.imem_req), 32'(t.e_req));
    chk({tag, ".addr"}, bus.imem_addr, t.e_addr);
    chk({tag, ".valid"}, 32'(bus.if_valid), 32'(t.e_valid));
    if (t.e_valid) begin
      chk({tag, ".pc"}, bus.if_pc, t.e_pc);
      chk({tag, ".instr"}, bus.if_instr, t.e_instr);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req"}, 32'(bus.imem_req), 32'd0);
    chk({tag, ".addr"}, bus.imem_addr, 32'h100);
    chk({tag, ".valid"}, 32'(bus.if_valid), 32'd0);
    chk({tag, ".instr"}, bus.if_instr, 32'h0000_0013);
    chk({tag, ".pc"}, bus.if_pc, 32'h100);
  endtask

  // Randomized-phase reference model state (transaction level)
  logic [31:0] m_addr, m_gaddr, m_hpc;
  logic        m_idle, m_pend, m_stale, m_hold;
  int          m_lat, consumed;

  initial begin
    logic        exp_req, g, rv, rdy, rdr;
    logic [31:0] rd, rp;

    drive(0, 0, 32'h0, 0, 0, 32'h0);
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // gnt rv rdata          rdy rdr rpc           | req addr          vld pc            instr
    tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h100,       0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h100,       0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 1, 32'hD000_0100,  1, 0, 32'h0,          0, 32'h100,       1, 32'h100,       32'hD000_0100));
    tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h104,       0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h104,       0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 1, 32'hD000_0104,  0, 0, 32'h0,          0, 32'h104,       1, 32'h104,       32'hD000_0104));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,          0, 32'h104,       1, 32'h104,       32'hD000_0104));
    tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h108,       0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 32'h0,          1, 1, 32'h403,        0, 32'h400,       0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 1, 32'hD000_0108,  1, 0, 32'h0,          1, 32'h400,       0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h400,       0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 1, 32'h200,        0, 32'h200,       0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 1, 32'hD000_0400,  1, 0, 32'h0,          1, 32'h200,       0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h200,       0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 1, 32'hD000_0200,  1, 0, 32'h0,          0, 32'h200,       1, 32'h200,       32'hD000_0200));
    tbl.push_back(mk(0, 0, 32'h0,          1, 1, 32'h300,        1, 32'h300,       0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          1, 1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'hFFFF_FFFC, 0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 1, 32'hDFFF_FFFC,  1, 0, 32'h0,          0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'hDFFF_FFFC));
    tbl.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,         0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // Asynchronous reset while the 0x0 fetch is outstanding.
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    // Late responses for the abandoned fetch land in IDLE and REQ.
    apply(mk(0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0, 1, 32'h100, 0, 32'h0, 32'h0), "late0");
    apply(mk(0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0, 1, 32'h100, 0, 32'h0, 32'h0), "late1");
    apply(mk(1, 0, 32'h0,         1, 0, 32'h0, 0, 32'h100, 0, 32'h0, 32'h0), "late2");
    apply(mk(0, 1, 32'hD000_0100, 1, 0, 32'h0, 0, 32'h100, 1, 32'h100, 32'hD000_0100), "late3");

    // Randomized phase against the transaction-level model.
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_addr = 32'h100; m_gaddr = 32'h0; m_hpc = 32'h0;
    m_idle = 1; m_pend = 0; m_stale = 0; m_hold = 0; m_lat = 0; consumed = 0;

    for (int c = 0; c < 3000; c++) begin
      // A new fetch is expected whenever nothing is outstanding or held.
      exp_req = !m_idle && !m_pend && !m_hold;
      chk("rnd.req", 32'(bus.imem_req), 32'(exp_req));
      if (exp_req) chk("rnd.addr", bus.imem_addr, m_addr);
      chk("rnd.valid", 32'(bus.if_valid), 32'(m_hold));
      if (m_hold) begin
        chk("rnd.pc", bus.if_pc, m_hpc);
        chk("rnd.instr", bus.if_instr, mem_word(m_hpc));
      end

      g   = exp_req && ($urandom_range(0, 1) == 1);
      rv  = m_pend && (m_lat == 0);
      rd  = rv ? mem_word(m_gaddr) : $urandom;
      rdy = ($urandom_range(0, 9) < 7);
      rdr = ($urandom_range(0, 9) == 0);
      rp  = $urandom;
      drive(g, rv, rd, rdy, rdr, rp);

      m_idle = 0;
      if (m_hold && (rdr || rdy)) begin
        if (!rdr) begin
          consumed++;
          m_addr = m_hpc + 32'd4;
        end
        m_hold = 0;
      end
      if (rv) begin
        m_pend = 0;
        if (!m_stale && !rdr) begin
          m_hold = 1;
          m_hpc  = m_gaddr;
        end
      end else if (m_pend) begin
        if (m_lat > 0) m_lat--;
        if (rdr) m_stale = 1;
      end
      if (g) begin
        m_pend  = 1;
        m_gaddr = m_addr;
        m_stale = rdr;
        m_lat   = $urandom_range(0, 2);
      end
      if (rdr) m_addr = rp & 32'hFFFF_FFFC;

      @(posedge clk);
      @(negedge clk);
    end
    chk("rnd.progress", 32'(consumed > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
